// File: rtl/define.v
// Shared width definitions for the global-buffer datapath.
//   WORD_SIZE       : width of one global-buffer word
//   GBUFF_INDX_SIZE : width of a global-buffer index (buffer depth = 2**GBUFF_INDX_SIZE)
`ifndef GBUFF_DEFINE_V
`define GBUFF_DEFINE_V

`define WORD_SIZE       16
`define GBUFF_INDX_SIZE 8

`endif

// File: rtl/gbuff_reader.sv
// -----------------------------------------------------------------------------
// gbuff_reader
//
// Burst reader for the global buffer. A single-cycle start pulse in IDLE
// captures a base index and a word count. The block then walks consecutive
// buffer indices (wrapping at the top of the buffer), collects the words the
// buffer returns one cycle later, and streams them out through a 2-entry
// valid/ready FIFO. A one-cycle done pulse marks the point where every word
// of the burst has been handed downstream.
//
// The buffer is only ever read: gb_wr_en is tied low.
//
// Ports
//   clk        in   1                    system clock, all state on posedge
//   rst        in   1                    asynchronous, active-high reset
//   start      in   1                    begin a burst (sampled only in IDLE)
//   base       in   GBUFF_INDX_SIZE      first buffer index of the burst
//   len        in   GBUFF_INDX_SIZE+1    number of words, 0..2**GBUFF_INDX_SIZE
//   busy       out  1                    high in every state but IDLE
//   done       out  1                    one-cycle pulse at burst completion
//   gb_wr_en   out  1                    buffer write enable, always 0
//   gb_index   out  GBUFF_INDX_SIZE      registered buffer index
//   gb_rdata   in   WORD_SIZE            buffer data for last cycle's index
//   out_valid  out  1                    out_data holds a valid word
//   out_data   out  WORD_SIZE            head word of the output FIFO
//   out_ready  in   1                    downstream accepts out_data
// -----------------------------------------------------------------------------
`include "define.v"

module gbuff_reader (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [`GBUFF_INDX_SIZE-1:0]   base,
    input  logic [`GBUFF_INDX_SIZE:0]     len,
    output logic                          busy,
    output logic                          done,
    output logic                          gb_wr_en,
    output logic [`GBUFF_INDX_SIZE-1:0]   gb_index,
    input  logic [`WORD_SIZE-1:0]         gb_rdata,
    output logic                          out_valid,
    output logic [`WORD_SIZE-1:0]         out_data,
    input  logic                          out_ready
);

    localparam int IW = `GBUFF_INDX_SIZE;
    localparam int DW = `WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;

    // Burst bookkeeping
    logic [IW-1:0]  addr;        // next index to issue
    logic [IW:0]    remaining;   // reads still to issue
    logic           inflight;    // a read was issued last cycle; gb_rdata is live

    // Output FIFO (two entries, circular)
    logic [DW-1:0]  fifo_mem [2];
    logic           rd_ptr;
    logic           wr_ptr;
    logic [1:0]     count;

    logic           push;
    logic           pop;
    logic           issue;
    logic           accept_start;
    logic           last_issue;
    logic [2:0]     occupancy;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign accept_start = (state == IDLE) && start && (len != '0);

    assign push = inflight;
    assign pop  = out_valid && out_ready;

    // Words that will sit in the FIFO once this cycle's traffic settles: what
    // is stored, plus the word arriving now, minus the word leaving now. A new
    // read is only issued if its word is guaranteed a free slot next cycle.
    // pop implies count >= 1, so this never underflows.
    assign occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

    assign issue      = (state == READ) && (remaining != '0) && (occupancy < 3'd2);
    assign last_issue = issue && (remaining == {{IW{1'b0}}, 1'b1});

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (last_issue) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                // Last word has landed in the FIFO and left it.
                if (!inflight && (count == 2'd0)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE:    busy = 1'b0;
            READ:    busy = 1'b1;
            DRAIN:   busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read issue: address, remaining count, in-flight flag, buffer index
    // -------------------------------------------------------------------------
    // gb_index is a register that always holds the index to present in the
    // cycle a read issues: it is loaded with base when the burst is accepted
    // and advanced to the following index on every issue except the last, so
    // after the burst it keeps the final index that was read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            gb_index  <= '0;
        end else begin
            inflight <= issue;
            if (accept_start) begin
                addr      <= base;
                remaining <= len;
                gb_index  <= base;
            end else if (issue) begin
                // IW-bit add: wraps from the top index back to 0.
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
                if (!last_issue) begin
                    gb_index <= addr + 1'b1;
                end
            end
        end
    end

    assign gb_wr_en = 1'b0;

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    // NOTE: the storage entries are reset as well because out_data is read
    // straight from them and must come out of reset as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= gb_rdata;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Both come from registers only; a push never touches the head entry
    // while it is valid, so out_data holds steady under backpressure.
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];

    // -------------------------------------------------------------------------
    // A push into a full FIFO with nothing leaving would lose a word; the
    // issue throttle is meant to make that unreachable.
    // -------------------------------------------------------------------------
    fifo_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && !pop && (count == 2'd2))
    );

endmodule

// File: tb/tb_gbuff_reader.sv
`include "define.v"

module tb_gbuff_reader;

  localparam int IW    = `GBUFF_INDX_SIZE;
  localparam int DW    = `WORD_SIZE;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] base;
  logic [IW:0]   len;
  logic          busy;
  logic          done;
  logic          gb_wr_en;
  logic [IW-1:0] gb_index;
  logic [DW-1:0] gb_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;

  gbuff_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .gb_wr_en  (gb_wr_en),
    .gb_index  (gb_index),
    .gb_rdata  (gb_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Global buffer: gbuff[i] = i + 100, one-cycle read latency.
  logic [DW-1:0] gbuff [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) gbuff[i] = DW'(i + 100);
  always @(posedge clk) gb_rdata <= gbuff[gb_index];

  // Bookkeeping
  int vectors = 0;
  int errors  = 0;
  int done_cnt = 0;
  int cyc = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] rx_log [$];
  int            rx_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready driver (sole writer of out_ready).
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: every cycle, the head of the expected-word queue must be
  // what the DUT presents; an accepted word retires it.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("gb_wr_en", 32'(gb_wr_en), 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            rx_log.push_back(out_data);
            rx_cyc.push_back(cyc);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  // Expected stream for a burst: consecutive indices modulo the buffer depth.
  task automatic load_model(input int b, input int l);
    rx_log.delete();
    rx_cyc.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(DW'(((b + i) % DEPTH) + 100));
  endtask

  task automatic pulse_start(input int b, input int l);
    @(posedge clk); #1;
    start = 1'b1;
    base  = IW'(b);
    len   = (IW+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for a done pulse, then checks the burst closed cleanly.
  task automatic finish_burst(input string name, input int l, input int d0, input int limit);
    int c = 0;
    while (done_cnt == d0 && c < limit) begin
      @(negedge clk); #2;
      c++;
    end
    check({name, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    @(negedge clk); #2;
    check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    check({name, "_words_rx"}, 32'(rx_log.size()), 32'(l));
    check({name, "_model_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_rx(input string name, input int idx, input int exp);
    if (idx < rx_log.size()) check(name, 32'(rx_log[idx]), 32'(exp));
    else check({name, "_missing"}, 32'(rx_log.size()), 32'(idx + 1));
  endtask

  task automatic check_gap(input string name, input int i0, input int i1, input int gap);
    if (i1 < rx_cyc.size()) check(name, 32'(rx_cyc[i1] - rx_cyc[i0]), 32'(gap));
    else check({name, "_missing"}, 32'(rx_cyc.size()), 32'(i1 + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    len   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_gb_index",  32'(gb_index),  32'd0);
    check("rst_gb_wr_en",  32'(gb_wr_en),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // base=4 len=3, always ready: latency, order, back-to-back output
    ready_mode = 1;
    d0 = done_cnt;
    load_model(4, 3);
    pulse_start(4, 3);
    @(negedge clk); #1;
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    check("lat_c1_busy",  32'(busy),      32'd1);
    @(negedge clk); #1;
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    check("lat_c3_valid", 32'(out_valid), 32'd1);
    check("lat_c3_data",  32'(out_data),  32'd104);
    finish_burst("b4", 3, d0, 50);
    check_rx("b4_w0", 0, 104);
    check_rx("b4_w1", 1, 105);
    check_rx("b4_w2", 2, 106);
    check_gap("b4_back_to_back", 0, 2, 2);

    // len=0: immediate done, index untouched (still the last index read, 6)
    d0 = done_cnt;
    load_model(7, 0);
    pulse_start(7, 0);
    @(negedge clk); #1;
    check("len0_done_c1",  32'(done),      32'd1);
    check("len0_gb_index", 32'(gb_index),  32'd6);
    check("len0_no_valid", 32'(out_valid), 32'd0);
    finish_burst("len0", 0, d0, 10);
    check("len0_gb_index_after", 32'(gb_index), 32'd6);

    // base=10 len=4, downstream stalled for the first 6 cycles
    ready_mode = 0;
    d0 = done_cnt;
    load_model(10, 4);
    pulse_start(10, 4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      if (c >= 3) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data",  32'(out_data),  32'd110);
      end
    end
    ready_mode = 1;
    finish_burst("stall", 4, d0, 50);
    check_rx("stall_w0", 0, 110);
    check_rx("stall_w1", 1, 111);
    check_rx("stall_w2", 2, 112);
    check_rx("stall_w3", 3, 113);

    // base=254 len=4: index wraps 255 -> 0
    d0 = done_cnt;
    load_model(254, 4);
    pulse_start(254, 4);
    finish_burst("wrap", 4, d0, 50);
    check_rx("wrap_w0", 0, 354);
    check_rx("wrap_w1", 1, 355);
    check_rx("wrap_w2", 2, 100);
    check_rx("wrap_w3", 3, 101);
    check_gap("wrap_throughput", 0, 3, 3);

    // start re-pulsed during READ is ignored
    d0 = done_cnt;
    load_model(20, 5);
    pulse_start(20, 5);
    @(posedge clk); #1;
    start = 1'b1;
    base  = IW'(200);
    len   = (IW+1)'(9);
    @(posedge clk); #1;
    start = 1'b0;
    finish_burst("restart", 5, d0, 50);
    check_rx("restart_w4", 4, 124);

    // Reset in the middle of a stalled burst
    ready_mode = 0;
    d0 = done_cnt;
    load_model(50, 8);
    pulse_start(50, 8);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 1;
    repeat (5) begin
      @(negedge clk); #2;
    end
    check("midrst_no_done",  32'(done_cnt - d0), 32'd0);
    check("midrst_idle",     32'(busy),           32'd0);
    check("midrst_gb_index", 32'(gb_index),       32'd0);

    // Fresh burst after reset
    d0 = done_cnt;
    load_model(60, 2);
    pulse_start(60, 2);
    finish_burst("postrst", 2, d0, 50);
    check_rx("postrst_w0", 0, 160);
    check_rx("postrst_w1", 1, 161);

    // Full-depth burst with random backpressure
    ready_mode = 2;
    d0 = done_cnt;
    load_model(37, 256);
    pulse_start(37, 256);
    finish_burst("full", 256, d0, 4000);
    check_rx("full_first", 0, 137);
    check_rx("full_last", 255, 136);
    ready_mode = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/gbuff_reader.md
GBUFF_READER -- requirements
Module: gbuff_reader

Interface
REQ-001 SHALL take widths from define.v: WORD_SIZE is the data width, GBUFF_INDX_SIZE is the index width; no module parameters.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a burst read; sampled only in IDLE.
REQ-006 base  input  GBUFF_INDX_SIZE  first buffer index of the burst; sampled with start.
REQ-007 len  input  GBUFF_INDX_SIZE+1  number of words to read, 0..2^GBUFF_INDX_SIZE; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at burst completion.
REQ-010 gb_wr_en  output  1  drives the global buffer wr_en; held 0 at all times, so the buffer is in read mode.
REQ-011 gb_index  output  GBUFF_INDX_SIZE  drives the global buffer index; registered.
REQ-012 gb_rdata  input  WORD_SIZE  global buffer data_out; carries the word of the index presented in the previous cycle.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_data  output  WORD_SIZE  head word of the output FIFO.
REQ-015 out_ready  input  1  downstream accepts the word; a transfer occurs on a cycle with out_valid&&out_ready.

Function
REQ-016 SHALL implement the FSM IDLE, READ, DRAIN, DONE, with state held in registers.
REQ-017 IDLE: start=1 with len!=0 -> READ, with addr=base and remaining=len; start=1 with len==0 -> DONE; start=0 -> stay in IDLE.
REQ-018 SHALL ignore start in READ, DRAIN and DONE, with no effect on addr, remaining or the FIFO.
REQ-019 SHALL contain a 2-entry output FIFO (count 0..2) and a 1-bit in-flight flag marking a read issued in the previous cycle.
REQ-020 READ issue condition: remaining>0 and (count + inflight - pop) < 2, where pop = out_valid&&out_ready in the same cycle.
REQ-021 On issue: gb_index=addr in that cycle; then on the edge addr<=addr+1, remaining<=remaining-1, inflight<=1.
REQ-022 When no read is issued: inflight<=0 and gb_index holds its last value.
REQ-023 SHALL push gb_rdata into the FIFO in the cycle after issue (inflight=1); a push and a pop in the same cycle SHALL leave count unchanged and preserve word order.
REQ-024 addr SHALL wrap modulo 2^GBUFF_INDX_SIZE (max index -> 0) with no error indication.
REQ-025 READ -> DRAIN on the edge on which the last read issues (remaining goes 1 -> 0).
REQ-026 DRAIN -> DONE when inflight=0 and count=0, i.e. every word has been transferred downstream.
REQ-027 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-028 out_valid = (count!=0), driven from registers only; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 Latency: the first read issues in the first cycle in READ; that word is at out_valid in the third cycle after the start edge.
REQ-030 Throughput: with out_ready held 1, one word per cycle sustained, with no bubbles after the first word.
REQ-031 The FIFO SHALL never overflow; a push with count=2 and no pop is a design error and SHALL be checked by a verification assertion.

Reset
REQ-032 rst=1 SHALL asynchronously set: state=IDLE, busy=0, done=0, out_valid=0, out_data=0, gb_index=0, gb_wr_en=0, count=0, inflight=0, addr=0, remaining=0.
REQ-033 A reset mid-burst SHALL drop pending words with no done pulse; the first start after rst deasserts SHALL begin a fresh burst.

Verification
(Global buffer preloaded with gbuff[i]=i+100, GBUFF_INDX_SIZE=8.)
REQ-034 base=4, len=3, out_ready=1 -> out_data 104,105,106 on three consecutive valid cycles; then done pulses once and busy falls.
REQ-035 base=10, len=4, out_ready=0 for the first 6 cycles -> at most 2 reads issued, out_data held at 110; after release -> 110,111,112,113 with no loss or duplicates.
REQ-036 base=254, len=4 -> out_data 354,355,100,101 (addresses 254,255,0,1 wrap).
REQ-037 len=0 start -> done pulse one cycle after the start edge, out_valid never 1, gb_index unchanged.
REQ-038 start pulsed during READ -> ignored, only the original burst delivered; rst asserted mid-burst -> busy=0 and out_valid=0 immediately, with no done pulse.
REQ-039 Random out_ready with len=256 -> all 256 words received in order, gb_wr_en never 1, FIFO-overflow assertion never fires.
